// File: rtl/rv_idex_pipe.sv
// rv_idex_pipe: ID/EX pipeline stage with valid/ready handshake and a two-entry skid buffer.
//
// Storage is a main entry, which drives the outputs, and a skid entry that is always younger.
// Every output is a flop output, so there are no combinational input-to-output paths.
// in_ready is registered as (next occupancy < 2). Because of that, a push can never arrive
// while both entries are full.
//
// Optional feature: define RV_IDEX_WB_PATCH_EN to enable the write-back patch. With it enabled,
// a matching write-back (index != 0) overwrites the rdata of an incoming entry or a held entry.
// The popped value is always the pre-patch value.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_i                  drop all stored and incoming entries
//   in_valid_i / in_ready_o  ID-side handshake
//   in_ctrl_i, in_aux_i      control bits and imm/pc/rd payload
//   in_rs{1,2}_idx_i         source register indices
//   in_rdata{1,2}_i          regfile read data
//   wb_we_i/idx_i/data_i     write-back port (used only by the patch feature)
//   out_valid_o/out_ready_i  EX-side handshake
//   out_*                    head-entry fields; ctrl is zero while out_valid_o=0
//   occupancy_o              number of stored entries (0..2)
module rv_idex_pipe #(
  parameter int unsigned WORD_WTH    = 32,
  parameter int unsigned REG_INX_WTH = 5,
  parameter int unsigned CTRL_WTH    = 16,
  parameter int unsigned AUX_WTH     = 101
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [CTRL_WTH-1:0]    in_ctrl_i,
  input  logic [AUX_WTH-1:0]     in_aux_i,
  input  logic [REG_INX_WTH-1:0] in_rs1_idx_i,
  input  logic [REG_INX_WTH-1:0] in_rs2_idx_i,
  input  logic [WORD_WTH-1:0]    in_rdata1_i,
  input  logic [WORD_WTH-1:0]    in_rdata2_i,
  input  logic                   wb_we_i,
  input  logic [REG_INX_WTH-1:0] wb_idx_i,
  input  logic [WORD_WTH-1:0]    wb_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [CTRL_WTH-1:0]    out_ctrl_o,
  output logic [AUX_WTH-1:0]     out_aux_o,
  output logic [REG_INX_WTH-1:0] out_rs1_idx_o,
  output logic [REG_INX_WTH-1:0] out_rs2_idx_o,
  output logic [WORD_WTH-1:0]    out_rdata1_o,
  output logic [WORD_WTH-1:0]    out_rdata2_o,
  output logic [1:0]             occupancy_o
);

  typedef struct packed {
    logic [CTRL_WTH-1:0]    ctrl;
    logic [AUX_WTH-1:0]     aux;
    logic [REG_INX_WTH-1:0] rs1_idx;
    logic [REG_INX_WTH-1:0] rs2_idx;
    logic [WORD_WTH-1:0]    rdata1;
    logic [WORD_WTH-1:0]    rdata2;
  } entry_t;

  // Empty slots are kept all-zero. Their indices are then 0, so they can never be patched,
  // and a bubble drives zero ctrl.
  entry_t     main_q, main_d, skid_q, skid_d;
  entry_t     main_p, skid_p, in_raw, in_ent;
  logic [1:0] occ_q, occ_d;
  logic       ready_q, valid_q;
  logic       push, pop;

`ifdef RV_IDEX_WB_PATCH_EN
  function automatic entry_t patch(input entry_t                  e,
                                   input logic                    we,
                                   input logic [REG_INX_WTH-1:0]  idx,
                                   input logic [WORD_WTH-1:0]     data);
    entry_t r;
    r = e;
    if (we && (idx != '0) && (idx == e.rs1_idx)) r.rdata1 = data;
    if (we && (idx != '0) && (idx == e.rs2_idx)) r.rdata2 = data;
    return r;
  endfunction
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we_i, wb_idx_i, wb_data_i};
`endif

  always_comb begin
    in_raw = '{ctrl: in_ctrl_i, aux: in_aux_i, rs1_idx: in_rs1_idx_i, rs2_idx: in_rs2_idx_i,
                rdata1: in_rdata1_i, rdata2: in_rdata2_i};
`ifdef RV_IDEX_WB_PATCH_EN
    main_p = patch(main_q, wb_we_i, wb_idx_i, wb_data_i);
    skid_p = patch(skid_q, wb_we_i, wb_idx_i, wb_data_i);
    in_ent = patch(in_raw, wb_we_i, wb_idx_i, wb_data_i);
`else
    main_p = main_q;
    skid_p = skid_q;
    in_ent = in_raw;
`endif
  end

  assign push = in_valid_i && ready_q;
  assign pop  = valid_q && out_ready_i;

  always_comb begin
    main_d = main_p;
    skid_d = skid_p;
    occ_d  = occ_q;
    if (flush_i) begin
      main_d = '0;
      skid_d = '0;
      occ_d  = 2'd0;
    end else if (pop) begin
      if (occ_q == 2'd2) begin
        main_d = skid_p;
        if (push) begin
          skid_d = in_ent;
        end else begin
          skid_d = '0;
          occ_d  = 2'd1;
        end
      end else if (push) begin
        main_d = in_ent;
      end else begin
        main_d = '0;
        occ_d  = 2'd0;
      end
    end else if (push) begin
      // A push needs ready_q=1, so occupancy here is 0 or 1.
      if (occ_q == 2'd0) begin
        main_d = in_ent;
        occ_d  = 2'd1;
      end else begin
        skid_d = in_ent;
        occ_d  = 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q  <= '0;
      skid_q  <= '0;
      occ_q   <= 2'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      main_q  <= main_d;
      skid_q  <= skid_d;
      occ_q   <= occ_d;
      ready_q <= (occ_d != 2'd2);
      valid_q <= (occ_d != 2'd0);
    end
  end

  assign in_ready_o    = ready_q;
  assign out_valid_o   = valid_q;
  assign occupancy_o   = occ_q;
  assign out_ctrl_o    = main_q.ctrl;
  assign out_aux_o     = main_q.aux;
  assign out_rs1_idx_o = main_q.rs1_idx;
  assign out_rs2_idx_o = main_q.rs2_idx;
  assign out_rdata1_o  = main_q.rdata1;
  assign out_rdata2_o  = main_q.rdata2;

endmodule

// File: tb/tb_rv_idex_pipe.sv
// Bench for rv_idex_pipe: a queue-based model checked on every negedge, plus literal checks.
module tb_rv_idex_pipe;

  typedef struct packed {
    logic [15:0]  ctrl;
    logic [100:0] aux;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [31:0]  d1;
    logic [31:0]  d2;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, wb_we, out_valid, out_ready;
  logic [15:0]  in_ctrl, out_ctrl;
  logic [100:0] in_aux, out_aux;
  logic [4:0]   in_rs1, in_rs2, wb_idx, out_rs1, out_rs2;
  logic [31:0]  in_d1, in_d2, wb_data, out_d1, out_d2;
  logic [1:0]   occ;

  int total = 0;
  int bad   = 0;

  ent_t q[$];
  bit   m_ready = 1'b1;

  always #5 clk = ~clk;

  rv_idex_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_ctrl_i     (in_ctrl),
    .in_aux_i      (in_aux),
    .in_rs1_idx_i  (in_rs1),
    .in_rs2_idx_i  (in_rs2),
    .in_rdata1_i   (in_d1),
    .in_rdata2_i   (in_d2),
    .wb_we_i       (wb_we),
    .wb_idx_i      (wb_idx),
    .wb_data_i     (wb_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_ctrl_o    (out_ctrl),
    .out_aux_o     (out_aux),
    .out_rs1_idx_o (out_rs1),
    .out_rs2_idx_o (out_rs2),
    .out_rdata1_o  (out_d1),
    .out_rdata2_o  (out_d2),
    .occupancy_o   (occ)
  );

  function automatic ent_t mk(input int n);
    ent_t e;
    e.ctrl = 16'(n * 37 + 1);
    e.aux  = (101'(n) << 40) | 101'(32'h400 + n * 4);
    e.rs1  = 5'(n + 1);
    e.rs2  = 5'(n + 10);
    e.d1   = 32'hA000_0000 + 32'(n);
    e.d2   = 32'hB000_0000 + 32'(n);
    return e;
  endfunction

  function automatic ent_t wb_apply(input ent_t e);
    ent_t r = e;
`ifdef RV_IDEX_WB_PATCH_EN
    if (wb_we && wb_idx != 0 && wb_idx == r.rs1) r.d1 = wb_data;
    if (wb_we && wb_idx != 0 && wb_idx == r.rs2) r.d2 = wb_data;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the stage behaves as an in-order queue of at most 2 entries.
  always @(posedge clk) begin
    bit do_push, do_pop;
    ent_t n;
    n = '{ctrl: in_ctrl, aux: in_aux, rs1: in_rs1, rs2: in_rs2, d1: in_d1, d2: in_d2};
    if (rst || flush) begin
      q.delete();
      m_ready = 1'b1;
    end else begin
      do_push = in_valid && m_ready;
      do_pop  = (q.size() != 0) && out_ready;
      if (do_pop) void'(q.pop_front());
      foreach (q[i]) q[i] = wb_apply(q[i]);
      if (do_push) q.push_back(wb_apply(n));
      m_ready = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_valid", out_valid, q.size() != 0);
      chk("cmp_occ", occ, q.size());
      chk("cmp_ready", in_ready, m_ready);
      if (q.size() != 0) begin
        chk("cmp_ctrl", out_ctrl, q[0].ctrl);
        chk("cmp_aux", out_aux, q[0].aux);
        chk("cmp_rs1", out_rs1, q[0].rs1);
        chk("cmp_rs2", out_rs2, q[0].rs2);
        chk("cmp_rdata1", out_d1, q[0].d1);
        chk("cmp_rdata2", out_d2, q[0].d2);
      end else begin
        chk("cmp_bubble_ctrl", out_ctrl, 0);
      end
    end
  end

  task automatic set_in(input bit v, input ent_t e);
    in_valid = v;
    in_ctrl  = e.ctrl;
    in_aux   = e.aux;
    in_rs1   = e.rs1;
    in_rs2   = e.rs2;
    in_d1    = e.d1;
    in_d2    = e.d2;
  endtask

  task automatic cyc(input bit v, input ent_t e, input bit ordy, input bit fl);
    set_in(v, e);
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ent_t e;
    bit   acc;
    int   cnt;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    wb_we = 1'b0; wb_idx = '0; wb_data = '0;
    set_in(1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset
    chk("rst_valid", out_valid, 0);
    chk("rst_occ", occ, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_ctrl", out_ctrl, 0);
    rst = 1'b0;

    // Streaming: 8 back-to-back pushes, each visible one cycle later
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, mk(i), 1'b1, 1'b0);
      chk("stream_valid", out_valid, 1);
      chk("stream_aux", out_aux, mk(i).aux);
      chk("stream_occ_le1", occ <= 2'd1, 1);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drained", out_valid, 0);

    // Back-pressure: A, B fill both entries; C is held off
    cyc(1'b1, mk(20), 1'b0, 1'b0);
    cyc(1'b1, mk(21), 1'b0, 1'b0);
    chk("bp_occ2", occ, 2);
    chk("bp_ready0", in_ready, 0);
    chk("bp_head_a", out_aux, mk(20).aux);
    cyc(1'b1, mk(22), 1'b0, 1'b0);
    chk("bp_still_a", out_aux, mk(20).aux);
    cnt = 0;
    acc = 1'b0;
    while (!acc && cnt < 10) begin
      acc = in_ready;
      cyc(1'b1, mk(22), 1'b1, 1'b0);
      if (cnt == 0) chk("bp_pop_b", out_aux, mk(21).aux);
      cnt++;
    end
    chk("bp_c_accepted", acc, 1);
    set_in(1'b0, '0);
    chk("bp_pop_c", out_aux, mk(22).aux);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("bp_empty", out_valid, 0);

    // Flush with a full buffer and an incoming entry
    cyc(1'b1, mk(30), 1'b0, 1'b0);
    cyc(1'b1, mk(31), 1'b0, 1'b0);
    chk("fl_occ2", occ, 2);
    cyc(1'b1, mk(32), 1'b0, 1'b1);
    chk("fl_occ0", occ, 0);
    chk("fl_valid0", out_valid, 0);
    chk("fl_ctrl0", out_ctrl, 0);
    chk("fl_ready1", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("fl_dropped", out_valid, 0);
    end

    // Write-back patch on a held entry
    e = mk(40); e.rs1 = 5'd5; e.rs2 = 5'd0; e.d1 = 32'h1111_1111; e.d2 = 32'h2222_2222;
    cyc(1'b1, e, 1'b0, 1'b0);
    chk("wb_hold_d1", out_d1, 32'h1111_1111);
    wb_we = 1'b1; wb_idx = 5'd5; wb_data = 32'hDEAD_BEEF;
    cyc(1'b0, '0, 1'b0, 1'b0);
`ifdef RV_IDEX_WB_PATCH_EN
    chk("wb_patch_d1", out_d1, 32'hDEAD_BEEF);
`else
    chk("wb_nopatch_d1", out_d1, 32'h1111_1111);
`endif
    wb_idx = 5'd0; wb_data = 32'hCAFE_F00D;
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("wb_idx0_d2", out_d2, 32'h2222_2222);
    wb_we = 1'b0;
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("wb_popped", out_valid, 0);

    // Patch at capture
    e = mk(41); e.rs2 = 5'd7; e.d2 = 32'h5555;
    wb_we = 1'b1; wb_idx = 5'd7; wb_data = 32'h1234;
    cyc(1'b1, e, 1'b0, 1'b0);
    wb_we = 1'b0;
`ifdef RV_IDEX_WB_PATCH_EN
    chk("cap_patch_d2", out_d2, 32'h1234);
`else
    chk("cap_nopatch_d2", out_d2, 32'h5555);
`endif
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
